// File: rtl/ex_div_if.sv
// Handshake and write-back bundle for the iterative divider (ex_div).
// master: issuing pipeline stage; slave: the divider itself.
interface ex_div_if #(
  parameter int unsigned XLEN = 32
);
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic [4:0]      rd_addr_i;
  logic            flush_i;
  logic            ready_o;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;
  logic            reg_we_o;
  logic [4:0]      reg_waddr_o;
  logic [XLEN-1:0] reg_wdata_o;

  modport master (
    output start_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
    input  ready_o, busy_o, valid_o, result_o, reg_we_o, reg_waddr_o, reg_wdata_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
    output ready_o, busy_o, valid_o, result_o, reg_we_o, reg_waddr_o, reg_wdata_o
  );
endinterface

// File: rtl/ex_div.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU with register-file write-back.
// One quotient bit per cycle, MSB first; result appears 33 edges after acceptance.
// Optional macro DIV_FASTPATH_EN: divide-by-zero and signed overflow bypass the
// iteration and complete in the cycle after the accepting edge.
module ex_div #(
  parameter int unsigned XLEN = 32
) (
  input  logic   clk,
  input  logic   rst_n,
  ex_div_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] AllOnes = '1;

  state_e          state_q;
  logic [5:0]      cnt_q;
  logic [1:0]      op_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] dvd_q;    // raw dividend, needed for REM by zero
  logic [XLEN-1:0] dvs_q;    // divisor magnitude
  logic [XLEN-1:0] quo_q;    // shifts out dividend magnitude, shifts in quotient bits
  logic [XLEN-1:0] rem_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic            div0_q;
  logic            ovf_q;
  logic            valid_q;
  logic            we_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      waddr_q;

  logic            accept;
  logic            in_signed;
  logic            in_div0;
  logic            in_ovf;
  logic [XLEN-1:0] in_abs_dvd;
  logic [XLEN-1:0] in_abs_dvs;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;
  logic [XLEN-1:0] fin_res;
  logic            unused_msb;

  // Architecturally defined results for the corner cases that bypass the quotient math.
  function automatic logic [XLEN-1:0] special_res(input logic [1:0] op,
                                                  input logic [XLEN-1:0] dvd,
                                                  input logic div0);
    logic [XLEN-1:0] r;
    if (div0) r = op[1] ? dvd : AllOnes;
    else      r = op[1] ? '0 : MinNeg;
    return r;
  endfunction

  // Decode the incoming request: acceptance, sign handling and corner cases.
  always_comb begin
    accept     = (state_q == StIdle) && bus.start_i && !bus.flush_i;
    in_signed  = !bus.op_i[0];
    in_div0    = (bus.divisor_i == '0);
    in_ovf     = in_signed && (bus.dividend_i == MinNeg) && (bus.divisor_i == AllOnes);
    in_abs_dvd = (in_signed && bus.dividend_i[XLEN-1]) ? ('0 - bus.dividend_i) : bus.dividend_i;
    in_abs_dvs = (in_signed && bus.divisor_i[XLEN-1]) ? ('0 - bus.divisor_i) : bus.divisor_i;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    ge      = (shifted >= {1'b0, dvs_q});
    rem_nxt = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_nxt = {quo_q[XLEN-2:0], ge};
  end

  // Remainder is always below the divisor, so the top bits never carry information.
  assign unused_msb = ^{diff[XLEN], shifted[XLEN]};

  // Final sign fix-up or corner-case override once all quotient bits are in.
  always_comb begin
    fin_res = '0;
    if (div0_q || ovf_q)  fin_res = special_res(op_q, dvd_q, div0_q);
    else if (op_q[1])     fin_res = neg_rem_q ? ('0 - rem_q) : rem_q;
    else                  fin_res = neg_quo_q ? ('0 - quo_q) : quo_q;
  end

  // Control FSM, datapath registers and registered write-back outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      we_q      <= 1'b0;
      result_q  <= '0;
      waddr_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            op_q      <= bus.op_i;
            rd_q      <= bus.rd_addr_i;
            dvd_q     <= bus.dividend_i;
            dvs_q     <= in_abs_dvs;
            quo_q     <= in_abs_dvd;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= in_signed && (bus.dividend_i[XLEN-1] ^ bus.divisor_i[XLEN-1]);
            neg_rem_q <= in_signed && bus.dividend_i[XLEN-1];
            div0_q    <= in_div0;
            ovf_q     <= in_ovf;
            state_q   <= StCalc;
`ifdef DIV_FASTPATH_EN
            if (in_div0 || in_ovf) begin
              result_q <= special_res(bus.op_i, bus.dividend_i, in_div0);
              waddr_q  <= bus.rd_addr_i;
              valid_q  <= 1'b1;
              we_q     <= (bus.rd_addr_i != 5'd0);
              state_q  <= StDone;
            end
`endif
          end
        end
        StCalc: begin
          if (bus.flush_i) begin
            state_q <= StIdle;
          end else if (cnt_q == 6'd32) begin
            // All 32 bits resolved; this extra cycle registers the signed result.
            result_q <= fin_res;
            waddr_q  <= rd_q;
            valid_q  <= 1'b1;
            we_q     <= (rd_q != 5'd0);
            state_q  <= StDone;
          end else begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q + 6'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Status decode; a flush in DONE masks the pulse in that same cycle.
  always_comb begin
    bus.ready_o     = (state_q == StIdle);
    bus.busy_o      = (state_q == StCalc) || (state_q == StDone);
    bus.valid_o     = valid_q && !bus.flush_i;
    bus.reg_we_o    = we_q && !bus.flush_i;
    bus.result_o    = result_q;
    bus.reg_waddr_o = waddr_q;
    bus.reg_wdata_o = result_q;
  end

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed corner cases plus random operations
// checked against an arithmetic reference model.
module tb_ex_div;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  ex_div_if #(.XLEN(32)) bus ();

  ex_div #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic is_special(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // RISC-V M-extension semantics expressed with plain arithmetic.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'b00:   return $signed(a) / $signed(b);
      2'b01:   return a / b;
      2'b10:   return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  // Edges after acceptance until valid_o is seen (0 = cycle right after accept).
  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
`ifdef DIV_FASTPATH_EN
    return is_special(op, a, b) ? 0 : 33;
`else
    return (is_special(op, a, b) && 1'b0) ? 0 : 33;
`endif
  endfunction

  // Presents a request for exactly one edge; returns 1ns after that edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    bus.start_i    = 1'b1;
    bus.op_i       = op;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.rd_addr_i  = rd;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    int g = 0;
    int n = 0;
    while (!bus.ready_o && g < 100) begin @(posedge clk); #1; g++; end
    check({tag, " ready"}, {31'd0, bus.ready_o}, 32'd1);
    issue(op, a, b, rd);
    while (!bus.valid_o && n < 40) begin @(posedge clk); #1; n++; end
    check({tag, " latency"}, n, exp_lat(op, a, b));
    check({tag, " result"}, bus.result_o, model(op, a, b));
    check({tag, " wdata"}, bus.reg_wdata_o, model(op, a, b));
    check({tag, " we"}, {31'd0, bus.reg_we_o}, {31'd0, rd != 5'd0});
    check({tag, " waddr"}, {27'd0, bus.reg_waddr_o}, {27'd0, rd});
    @(posedge clk); #1;
    check({tag, " valid drop"}, {31'd0, bus.valid_o}, 32'd0);
    check({tag, " ready after"}, {31'd0, bus.ready_o}, 32'd1);
    check({tag, " result hold"}, bus.result_o, model(op, a, b));
  endtask

  task automatic count_valids(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.valid_o) cnt++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ready"}, {31'd0, bus.ready_o}, 32'd1);
    check({tag, " busy"}, {31'd0, bus.busy_o}, 32'd0);
    check({tag, " valid"}, {31'd0, bus.valid_o}, 32'd0);
    check({tag, " we"}, {31'd0, bus.reg_we_o}, 32'd0);
    check({tag, " result"}, bus.result_o, 32'd0);
    check({tag, " waddr"}, {27'd0, bus.reg_waddr_o}, 32'd0);
    check({tag, " wdata"}, bus.reg_wdata_o, 32'd0);
  endtask

  initial begin
    int cnt;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic [4:0]  rrd;

    bus.start_i = 1'b0; bus.op_i = 2'b00; bus.dividend_i = '0; bus.divisor_i = '0;
    bus.rd_addr_i = '0; bus.flush_i = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 5'd5);
    run_op("remu 100/7", 2'b11, 32'd100, 32'd7, 5'd5);
    run_op("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd9);
    run_op("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd9);
    run_op("div 5/0", 2'b00, 32'd5, 32'd0, 5'd1);
    run_op("remu 5/0", 2'b11, 32'd5, 32'd0, 5'd2);
    run_op("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3);
    run_op("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
    run_op("divu rd0", 2'b01, 32'd100, 32'd7, 5'd0);

    // Flush mid-calculation.
    issue(2'b01, 32'd100, 32'd7, 5'd6);
    repeat (9) @(posedge clk);
    #1 bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    check("flush ready", {31'd0, bus.ready_o}, 32'd1);
    count_valids(40, cnt);
    check("flush no valid", cnt, 32'd0);
    run_op("after flush", 2'b01, 32'd100, 32'd7, 5'd6);

    // Flush in DONE masks the pulse in that cycle.
    issue(2'b01, 32'd1000, 32'd3, 5'd7);
    repeat (33) @(posedge clk);
    #1;
    check("done reached", {31'd0, bus.valid_o}, 32'd1);
    bus.flush_i = 1'b1;
    #1;
    check("done flush valid", {31'd0, bus.valid_o}, 32'd0);
    check("done flush we", {31'd0, bus.reg_we_o}, 32'd0);
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    check("done flush ready", {31'd0, bus.ready_o}, 32'd1);

    // Start together with flush in IDLE is ignored.
    bus.start_i = 1'b1; bus.flush_i = 1'b1;
    bus.op_i = 2'b01; bus.dividend_i = 32'd50; bus.divisor_i = 32'd5; bus.rd_addr_i = 5'd8;
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    check("start+flush busy", {31'd0, bus.busy_o}, 32'd0);
    count_valids(40, cnt);
    check("start+flush no valid", cnt, 32'd0);

    // Start held while busy yields one result.
    bus.start_i = 1'b1;
    bus.op_i = 2'b01; bus.dividend_i = 32'd100; bus.divisor_i = 32'd7; bus.rd_addr_i = 5'd3;
    @(posedge clk); #1;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (bus.valid_o) cnt++;
    end
    bus.start_i = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.valid_o) cnt++;
    end
    check("held start one result", cnt, 32'd1);

    // Reset in the middle of an operation.
    issue(2'b01, 32'd100, 32'd7, 5'd11);
    repeat (16) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("mid reset");
    rst_n = 1'b1;
    count_valids(40, cnt);
    check("mid reset no valid", cnt, 32'd0);

    // Random operations, back-to-back.
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rrd = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3:       rb = 32'd0 - $urandom_range(1, 300);
        default: rb = $urandom;
      endcase
      run_op("random", rop, ra, rb, rrd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
